uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Byte FIFO between the UART TX MMIO write port (0x8000_0004) and the uart_tx serialiser.
//  Stores now accept every byte instead of dropping those that arrive while the UART is busy.
//  Drains one byte at a time with the tx_start/tx_busy handshake.
//  Exposes full/empty/count/overflow for the UART status read (0x8000_0008).
// PARAMETERS
//  DEPTH   16  FIFO entries; power of two, >= 2
//  DATA_W  8   bits per entry
// PORTS
//  clk           in   1                  system clock, all state on posedge
//  rst_n         in   1                  asynchronous reset, active low
//  wr_en         in   1                  MMIO store strobe to UART data address, one cycle per byte
//  wr_data       in   DATA_W             byte to enqueue (store data [7:0])
//  flush         in   1                  synchronous FIFO clear
//  clr_overflow  in   1                  synchronous clear of sticky overflow
//  tx_busy       in   1                  from uart_tx: frame in progress
//  tx_start      out  1                  to uart_tx: one-cycle start pulse
//  tx_data       out  DATA_W             to uart_tx: byte, stable while tx_start=1 and after
//  full          out  1                  count == DEPTH
//  empty         out  1                  count == 0
//  count         out  $clog2(DEPTH)+1    occupied entries, 0..DEPTH
//  overflow      out  1                  sticky: a write was dropped
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - Pointers=0, count=0, empty=1, full=0, overflow=0.
//   - tx_start=0, tx_data=0, FSM=IDLE.
//   - Deassertion takes effect on the next posedge.
//  Storage: circular buffer, rd_ptr/wr_ptr of $clog2(DEPTH) bits. Pointers wrap DEPTH-1 -> 0 naturally.
//  Push: wr_en && (!full || pop) writes mem[wr_ptr] and increments wr_ptr.
//  Drop: wr_en && full && !pop drops the byte, sets overflow, leaves count unchanged.
//  Pop: asserted only by the FSM on the IDLE->SEND transition.
//  Count update: push&pop -> unchanged; push only -> +1; pop only -> -1.
//  flush:
//   - Overrides push and pop in the same cycle: pointers and count go to 0.
//   - The FSM is not affected; an in-flight byte completes.
//  overflow:
//   - Set by a drop, cleared by clr_overflow.
//   - Set wins if both occur in the same cycle.
//  FSM (registered):
//   - IDLE:
//     - !empty && !tx_busy && !flush -> SEND.
//     - On that edge: pop, tx_data <= mem[rd_ptr], rd_ptr++.
//   - SEND:
//     - tx_start=1 for exactly this one cycle.
//     - -> ARM unconditionally.
//   - ARM (wait for UART to accept):
//     - tx_busy=1 -> DRAIN.
//     - If tx_busy is still 0 after 2 cycles in ARM -> IDLE (lost start; the byte is discarded, not retried).
//   - DRAIN: tx_busy=0 -> IDLE.
//  tx_start is a registered decode of state==SEND; it is never high on two consecutive cycles.
//  tx_data holds its value until the next pop.
//  Latency:
//   - Write sampled at edge E0 with FIFO empty, FSM IDLE, tx_busy=0.
//   - Pop and tx_data load at E1; tx_start high E1..E2.
//   - Minimum byte-to-byte spacing = UART frame time + 3 cycles (ARM->DRAIN->IDLE->SEND).
//  Boundary cases:
//   - Write to an empty FIFO in the same cycle the FSM checks empty is not visible to the FSM until next cycle.
//   - full and empty are never both 1.
//   - count never exceeds DEPTH.
// TESTING
//  1 Reset then idle:
//    - Required: empty=1, count=0, tx_start=0 for 20 cycles.
//    - Pulse rst_n low mid-SEND -> all outputs return to reset values in the same cycle.
//  2 Single byte: write 0x41 with tx_busy=0 and a model UART (busy 1 cycle after start, for 680 cycles).
//    - tx_start exactly 1 cycle, 1 cycle after wr_en; tx_data=0x41; count 1->0.
//  3 Burst of 5 bytes 0x30..0x34 on consecutive cycles.
//    - UART sees 5 starts in order 0x30..0x34.
//    - Each start occurs only after the previous tx_busy falls; max count=4.
//  4 Fill and overflow: hold tx_busy=1, write 17 bytes (DEPTH=16).
//    - full=1 after 16 writes; 17th byte dropped; overflow=1, count=16.
//    - clr_overflow -> overflow=0.
//  5 Full + simultaneous pop: FIFO full, release tx_busy.
//    - wr_en on the pop edge is accepted; count stays 16; the new byte is later transmitted last.
//    - Wrap-around order is preserved over 40 bytes.
//  6 Flush and lost start:
//    - flush with 8 queued -> count=0 next cycle; the in-flight byte still completes.
//    - tx_busy never rises -> FSM returns to IDLE after ARM timeout and the next byte is sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO between the UART TX data register and the uart_tx serialiser
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     flush,
    input  logic                     clr_overflow,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_ARM   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [1:0]        state_q, state_d;
    logic              arm_cnt_q, arm_cnt_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    logic full_w;
    logic empty_w;
    logic pop;
    logic push;
    logic drop;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // A byte leaves the FIFO only when the FSM launches it; flush blocks the launch.
    assign pop  = (state_q == S_IDLE) && !empty_w && !tx_busy && !flush;
    // When full, a write is still accepted if a pop frees the slot on the same edge.
    assign push = wr_en && (!full_w || pop) && !flush;
    assign drop = wr_en && full_w && !pop;

    // Pointer, occupancy and sticky-overflow next state; flush overrides push and pop.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
        if (drop)              overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;
        else                   overflow_d = overflow_q;
    end

    // Launch FSM: IDLE pops, SEND pulses start, ARM waits up to two cycles for busy, DRAIN waits for the frame.
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        tx_data_d = tx_data_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d   = S_SEND;
                    tx_data_d = mem_q[rd_ptr_q];
                end
            end
            S_SEND: begin
                state_d   = S_ARM;
                arm_cnt_d = 1'b0;
            end
            S_ARM: begin
                if (tx_busy)        state_d = S_DRAIN;
                else if (arm_cnt_q) state_d = S_IDLE;
                else                arm_cnt_d = 1'b1;
            end
            S_DRAIN: begin
                if (!tx_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        tx_start_d = (state_d == S_SEND);
    end

    // Storage array has no reset; only occupied entries are ever read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            arm_cnt_q  <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            arm_cnt_q  <= arm_cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign full     = full_w;
    assign empty    = empty_w;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a model UART and scoreboard
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;

    logic       busy_hold = 1'b0;
    logic       uart_en = 1'b0;
    int         uart_frame = 680;
    logic       m_busy;
    int         m_cnt;
    logic       prev_start;

    int         n_total = 0;
    int         n_pass = 0;
    int         rx_cnt = 0;
    int         lost_cnt = 0;
    int         cyc = 0;
    int         last_rx_cyc = 0;
    logic [7:0] exp_q [$];
    int         lost_cyc [$];
    logic [7:0] lost_data [$];

    assign tx_busy = m_busy | busy_hold;

    uart_tx_fifo #(.DEPTH(16), .DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .flush        (flush),
        .clr_overflow (clr_overflow),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Model UART: accepts a start when enabled, then stays busy for uart_frame cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy     <= 1'b0;
            m_cnt      <= 0;
            prev_start <= 1'b0;
        end else begin
            prev_start <= tx_start;
            if (tx_start) begin
                check("start_one_cycle", {31'b0, prev_start}, 32'd0);
                check("start_while_busy", {31'b0, m_busy}, 32'd0);
                if (uart_en) begin
                    if (exp_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
                    else check("rx_data", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
                    rx_cnt      <= rx_cnt + 1;
                    last_rx_cyc <= cyc;
                    m_busy      <= 1'b1;
                    m_cnt       <= uart_frame;
                end else begin
                    lost_cnt <= lost_cnt + 1;
                    lost_cyc.push_back(cyc);
                    lost_data.push_back(tx_data);
                end
            end else if (m_busy) begin
                if (m_cnt <= 1) m_busy <= 1'b0;
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic write(input logic [7:0] d, input bit will_send);
        wr_en   = 1'b1;
        wr_data = d;
        if (will_send) exp_q.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int k = 0;
        while (rx_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, rx_cnt, n);
    endtask

    task automatic wait_uart_idle(input int budget, input string tag);
        int k = 0;
        while (m_busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'b0, m_busy}, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int maxc;
        int base;
        int k;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_count", {27'b0, count}, 32'd0);
        check("rst_full", {31'b0, full}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_tx_start", {31'b0, tx_start}, 32'd0);
        check("rst_tx_data", {24'b0, tx_data}, 32'd0);
        rst_n = 1'b1;

        // 1: idle for 20 cycles, then reset in the middle of SEND
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(empty === 1'b1 && count === 5'd0 && tx_start === 1'b0)) ok = 1'b0;
        end
        check("idle_20", {31'b0, ok}, 32'd1);
        uart_en = 1'b0;
        write(8'hA5, 1'b0);
        write(8'h5A, 1'b0);
        check("send_before_rst", {31'b0, tx_start}, 32'd1);
        check("send_data_before_rst", {24'b0, tx_data}, 32'hA5);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_tx_start", {31'b0, tx_start}, 32'd0);
        check("mid_rst_tx_data", {24'b0, tx_data}, 32'd0);
        check("mid_rst_count", {27'b0, count}, 32'd0);
        check("mid_rst_empty", {31'b0, empty}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2: single byte with a full-length frame
        uart_en    = 1'b1;
        uart_frame = 680;
        write(8'h41, 1'b1);
        check("t2_count_after_wr", {27'b0, count}, 32'd1);
        check("t2_no_start_yet", {31'b0, tx_start}, 32'd0);
        @(negedge clk);
        check("t2_start", {31'b0, tx_start}, 32'd1);
        check("t2_tx_data", {24'b0, tx_data}, 32'h41);
        check("t2_count_after_pop", {27'b0, count}, 32'd0);
        @(negedge clk);
        check("t2_start_fell", {31'b0, tx_start}, 32'd0);
        check("t2_rx", rx_cnt, 32'd1);
        wait_uart_idle(800, "t2_frame_done");

        // 3: burst of five bytes on consecutive cycles
        uart_frame = 30;
        base = rx_cnt;
        maxc = 0;
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h30 + 8'(i);
            exp_q.push_back(8'h30 + 8'(i));
            @(negedge clk);
            if (int'(count) > maxc) maxc = int'(count);
        end
        wr_en = 1'b0;
        k = 0;
        while (rx_cnt < base + 5 && k < 400) begin
            @(negedge clk);
            if (int'(count) > maxc) maxc = int'(count);
            k++;
        end
        check("t3_rx5", rx_cnt, base + 5);
        check("t3_max_count", maxc, 32'd4);
        wait_uart_idle(100, "t3_frame_done");

        // 4: fill with the UART held busy, then overflow
        busy_hold = 1'b1;
        for (int i = 0; i < 16; i++) write(8'h50 + 8'(i), 1'b1);
        check("t4_full", {31'b0, full}, 32'd1);
        check("t4_empty", {31'b0, empty}, 32'd0);
        check("t4_count16", {27'b0, count}, 32'd16);
        check("t4_no_ovf_yet", {31'b0, overflow}, 32'd0);
        write(8'hEE, 1'b0);
        check("t4_overflow", {31'b0, overflow}, 32'd1);
        check("t4_count_after_drop", {27'b0, count}, 32'd16);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check("t4_ovf_cleared", {31'b0, overflow}, 32'd0);
        clr_overflow = 1'b1;
        write(8'hEF, 1'b0);
        clr_overflow = 1'b0;
        check("t4_set_wins", {31'b0, overflow}, 32'd1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check("t4_ovf_cleared2", {31'b0, overflow}, 32'd0);

        // 5: release busy while full with a write on the pop edge, then stream 40 bytes total
        uart_frame = 4;
        base = rx_cnt;
        busy_hold = 1'b0;
        write(8'h60, 1'b1);
        check("t5_count_pop_push", {27'b0, count}, 32'd16);
        check("t5_no_ovf", {31'b0, overflow}, 32'd0);
        for (int i = 0; i < 23; i++) begin
            k = 0;
            while (full && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (full) check("t5_wait_not_full", 32'd1, 32'd0);
            write(8'h61 + 8'(i), 1'b1);
        end
        wait_rx(base + 40, 2000, "t5_rx40");
        check("t5_queue_drained", exp_q.size(), 32'd0);
        check("t5_no_ovf_end", {31'b0, overflow}, 32'd0);
        wait_uart_idle(50, "t5_frame_done");

        // 6a: flush with 8 queued while one byte is in flight
        uart_frame = 20;
        base = rx_cnt;
        for (int i = 0; i < 9; i++) write(8'h70 + 8'(i), i == 0);
        check("t6_count8", {27'b0, count}, 32'd8);
        check("t6_inflight", {31'b0, m_busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("t6_flush_count", {27'b0, count}, 32'd0);
        check("t6_flush_empty", {31'b0, empty}, 32'd1);
        wait_uart_idle(50, "t6_inflight_done");
        repeat (10) @(negedge clk);
        check("t6_no_extra_rx", rx_cnt, base + 1);
        check("t6_no_lost", lost_cnt, 32'd0);

        // 6b: lost start, ARM timeout, next byte sent
        base = rx_cnt;
        uart_en = 1'b0;
        write(8'h90, 1'b0);
        write(8'h91, 1'b1);
        k = 0;
        while (lost_cnt < 1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t6_lost1", lost_cnt, 32'd1);
        uart_en = 1'b1;
        wait_rx(base + 1, 30, "t6_next_sent");
        if (lost_data.size() > 0) begin
            check("t6_lost_data", {24'b0, lost_data[0]}, 32'h90);
            check("t6_restart_gap", last_rx_cyc - lost_cyc[0], 32'd4);
        end else begin
            check("t6_lost_record", 32'd0, 32'd1);
        end
        wait_uart_idle(50, "t6_frame_done");
        check("end_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
